// File: rtl/clock_mon_pkg.sv
// Shared types and helpers for the divided-clock ratio monitor.
package clock_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StRun
    } mon_state_e;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, plus a history flop that
// yields single-cycle rise/fall strobes in the clk_in domain.
module sync_edge_det (
    input  logic clk_in,
    input  logic reset,
    input  logic d_in,
    output logic rise_out,
    output logic fall_out
);

    logic meta_q;
    logic s_q;
    logic s_prev_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            meta_q   <= d_in;
            s_q      <= meta_q;
            s_prev_q <= s_q;
        end
    end

    assign rise_out = s_q & ~s_prev_q;
    assign fall_out = ~s_q & s_prev_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures high/low/period of a divided clock in clk_in cycles, declares lock
// after LOCK_CNT good periods and flags ratio, duty and stuck-clock errors.
module clock_ratio_monitor
    import clock_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned EXP_DIV  = 4,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             clk_div_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] high_out,
    output logic [CNT_W-1:0] low_out,
    output logic [CNT_W-1:0] ratio_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(cnt_max(CNT_W));
    localparam int unsigned      GoodW   = $clog2(LOCK_CNT + 1);
    localparam logic [GoodW-1:0] GoodMax = GoodW'(LOCK_CNT);
    localparam logic [CNT_W:0]   ExpDiv  = (CNT_W + 1)'(EXP_DIV);
    localparam logic [CNT_W:0]   TolW    = (CNT_W + 1)'(TOL);

    logic rise, fall;

    sync_edge_det u_sync_edge_det (
        .clk_in   (clk_in),
        .reset    (reset),
        .d_in     (clk_div_in),
        .rise_out (rise),
        .fall_out (fall)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [GoodW-1:0] good_q, good_d;
    logic             have_high_q, have_high_d;
    logic             locked_q, locked_d;
    logic             period_valid_q, period_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic             err_set;

    // Candidate period: registered high phase plus the low phase ending now.
    logic [CNT_W:0]   sum_w;
    logic [CNT_W:0]   diff_w;
    logic [CNT_W-1:0] ratio_w;
    logic             good_w;
    logic [GoodW-1:0] good_inc_w;

    always_comb begin
        sum_w      = {1'b0, high_q} + {1'b0, cnt_q};
        ratio_w    = sum_w[CNT_W] ? CntMax : sum_w[CNT_W-1:0];
        diff_w     = ({1'b0, ratio_w} >= ExpDiv) ? ({1'b0, ratio_w} - ExpDiv)
                                                 : (ExpDiv - {1'b0, ratio_w});
        good_w     = (diff_w <= TolW) && (high_q != '0) && (cnt_q != '0);
        good_inc_w = (good_q == GoodMax) ? GoodMax : good_q + GoodW'(1);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        high_d         = high_q;
        low_d          = low_q;
        ratio_d        = ratio_q;
        good_d         = good_q;
        have_high_d    = have_high_q;
        locked_d       = locked_q;
        period_valid_d = 1'b0;
        err_pulse_d    = 1'b0;
        err_set        = 1'b0;

        if (!enable) begin
            state_d     = StIdle;
            cnt_d       = '0;
            good_d      = '0;
            have_high_d = 1'b0;
            locked_d    = 1'b0;
        end else begin
            if (rise || fall) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (rise) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (fall) begin
                        high_d      = cnt_q;
                        have_high_d = 1'b1;
                    end else if (rise) begin
                        if (have_high_q) begin
                            low_d          = cnt_q;
                            ratio_d        = ratio_w;
                            period_valid_d = 1'b1;
                            if (good_w) begin
                                good_d   = good_inc_w;
                                locked_d = (good_inc_w == GoodMax);
                            end else begin
                                good_d   = '0;
                                locked_d = 1'b0;
                                err_set  = 1'b1;
                            end
                        end
                    end else if (cnt_q == CntMax) begin
                        // Stuck clock: resynchronise so the timeout fires only once.
                        state_d     = StSync;
                        good_d      = '0;
                        locked_d    = 1'b0;
                        have_high_d = 1'b0;
                        err_set     = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        err_pulse_d  = err_set;
        err_sticky_d = err_set | (err_sticky_q & ~err_clr);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            high_q         <= '0;
            low_q          <= '0;
            ratio_q        <= '0;
            good_q         <= '0;
            have_high_q    <= 1'b0;
            locked_q       <= 1'b0;
            period_valid_q <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_sticky_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            high_q         <= high_d;
            low_q          <= low_d;
            ratio_q        <= ratio_d;
            good_q         <= good_d;
            have_high_q    <= have_high_d;
            locked_q       <= locked_d;
            period_valid_q <= period_valid_d;
            err_pulse_q    <= err_pulse_d;
            err_sticky_q   <= err_sticky_d;
        end
    end

    assign high_out     = high_q;
    assign low_out      = low_q;
    assign ratio_out    = ratio_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Scoreboard bench: a phase-level model predicts each reported period or
// timeout; a monitor pops and compares whenever the DUT pulses an output.
module tb_clock_ratio_monitor;

    localparam int CW      = 8;
    localparam int EXP_DIV = 4;
    localparam int TOL     = 0;
    localparam int LOCK    = 4;
    localparam int CMAX    = 255;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          enable;
    logic          clk_div_in;
    logic          err_clr;
    logic [CW-1:0] high_out, low_out, ratio_out;
    logic          period_valid, locked, err_pulse, err_sticky;

    clock_ratio_monitor #(
        .CNT_W    (CW),
        .EXP_DIV  (EXP_DIV),
        .TOL      (TOL),
        .LOCK_CNT (LOCK)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .clk_div_in   (clk_div_in),
        .err_clr      (err_clr),
        .high_out     (high_out),
        .low_out      (low_out),
        .ratio_out    (ratio_out),
        .period_valid (period_valid),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_sticky   (err_sticky)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit tmo;
        int high;
        int low;
        int ratio;
        bit err;
        bit lck;
        bit sticky;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state, tracked per phase of the divided clock.
    int m_level, m_len, m_high, m_good, m_last_ratio;
    bit m_run, m_have_high, m_locked, m_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_len = 0; m_high = 0; m_good = 0; m_last_ratio = 0;
        m_run = 0; m_have_high = 0; m_locked = 0; m_sticky = 0;
    endtask

    task automatic model_edge(input int lvl);
        int   hi, lo, r, d;
        bit   ok;
        exp_t e;
        lo = (m_len > CMAX) ? CMAX : m_len;
        if (lvl == 1) begin
            if (!m_run) begin
                m_run = 1;
            end else if (m_have_high) begin
                hi = m_high;
                r  = (hi + lo > CMAX) ? CMAX : hi + lo;
                d  = (r > EXP_DIV) ? r - EXP_DIV : EXP_DIV - r;
                ok = (d <= TOL) && (hi != 0) && (lo != 0);
                if (ok) begin
                    if (m_good < LOCK) m_good++;
                    if (m_good == LOCK) m_locked = 1;
                end else begin
                    m_good = 0; m_locked = 0; m_sticky = 1;
                end
                e.tmo = 0; e.high = hi; e.low = lo; e.ratio = r; e.err = !ok;
                e.lck = m_locked; e.sticky = m_sticky;
                sb.push_back(e);
                m_last_ratio = r;
            end
        end else if (m_run) begin
            m_high = lo;
            m_have_high = 1;
        end
    endtask

    task automatic model_timeout();
        exp_t e;
        m_run = 0; m_have_high = 0; m_good = 0; m_locked = 0; m_sticky = 1;
        e.tmo = 1; e.high = 0; e.low = 0; e.ratio = 0; e.err = 1; e.lck = 0; e.sticky = 1;
        sb.push_back(e);
    endtask

    // Drive clk_div_in at level lvl for n clk_in samples, updating the model.
    task automatic seg(input int lvl, input int n);
        if (lvl != m_level) begin
            model_edge(lvl);
            m_level = lvl;
            m_len   = 0;
        end
        if (m_run && m_len < 256 && m_len + n >= 256) model_timeout();
        m_len += n;
        clk_div_in = (lvl != 0);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic periods(input int hi, input int lo, input int count);
        for (int i = 0; i < count; i++) begin
            seg(1, hi);
            seg(0, lo);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (!reset && (period_valid || err_pulse)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got pv=%0d err=%0d expected none at %0t",
                         period_valid, err_pulse, $time);
            end else begin
                e = sb.pop_front();
                if (e.tmo) begin
                    chk("tmo_period_valid", period_valid, 0);
                    chk("tmo_err_pulse", err_pulse, 1);
                    chk("tmo_locked", locked, 0);
                    chk("tmo_err_sticky", err_sticky, 1);
                end else begin
                    chk("period_valid", period_valid, 1);
                    chk("high_out", high_out, e.high);
                    chk("low_out", low_out, e.low);
                    chk("ratio_out", ratio_out, e.ratio);
                    chk("err_pulse", err_pulse, e.err);
                    chk("locked", locked, e.lck);
                    chk("err_sticky", err_sticky, e.sticky);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1'b1; enable = 1'b0; clk_div_in = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_high", high_out, 0);
        chk("rst_low", low_out, 0);
        chk("rst_ratio", ratio_out, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_sticky", err_sticky, 0);
        reset = 1'b0;
        enable = 1'b1;
        seg(0, 4);

        // T1: clean /4, lock on 4th reported period
        periods(2, 2, 7);
        chk("t1_sticky", err_sticky, 0);
        // T2: switch to /6
        periods(3, 3, 2);
        // T3: 3/1 duty still /4, then a glitch
        periods(3, 1, 6);
        seg(1, 1); seg(0, 1); seg(1, 1); seg(0, 1);
        periods(2, 2, 5);

        // Randomised mix of good and bad periods
        for (int i = 0; i < 40; i++) begin
            int hi, lo;
            if ($urandom_range(0, 3) != 0) begin
                hi = $urandom_range(1, 3);
                lo = 4 - hi;
            end else begin
                hi = $urandom_range(1, 6);
                lo = $urandom_range(1, 6);
            end
            periods(hi, lo, 1);
        end

        // T4: lock, stuck high, relock
        periods(2, 2, 5);
        seg(1, 300);
        seg(0, 2);
        periods(2, 2, 6);

        // T5: clear held across new errors, then released
        seg(0, 4);
        err_clr = 1'b1;
        seg(1, 1); seg(0, 1); seg(1, 2); seg(0, 6);
        err_clr = 1'b0;
        m_sticky = 0;
        seg(0, 1);
        chk("t5_sticky_cleared", err_sticky, 0);
        periods(2, 2, 6);

        // T6a: reset mid-period while locked
        seg(1, 1);
        reset = 1'b1;
        clk_div_in = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("t6_rst_high", high_out, 0);
        chk("t6_rst_low", low_out, 0);
        chk("t6_rst_ratio", ratio_out, 0);
        chk("t6_rst_pv", period_valid, 0);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_err_pulse", err_pulse, 0);
        chk("t6_rst_err_sticky", err_sticky, 0);
        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b0;
        seg(0, 4);
        periods(2, 2, 6);
        seg(0, 2);
        chk("t6_locked_before_drop", locked, 1);

        // T6b: enable dropped mid-run
        enable = 1'b0;
        m_run = 0; m_have_high = 0; m_good = 0; m_locked = 0;
        @(posedge clk_in);
        #1;
        chk("t6_locked_after_drop", locked, 0);
        chk("t6_ratio_held", ratio_out, m_last_ratio);
        repeat (6) @(posedge clk_in);
        #1;
        chk("t6_ratio_still_held", ratio_out, m_last_ratio);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_in);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
